// File: rtl/fwd_scoreboard.sv
// Scoreboard forwarding/hazard unit between ID and EX: one entry per architectural
// register tracks the remaining EX latency and the forwarding stage of its result.

module fwd_sb_entry #(
  parameter int LAT_W   = 4,
  parameter int AGE_W   = 3,
  parameter int NUM_FWD = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rec,
  input  logic [LAT_W-1:0] rec_lat,
  output logic             valid,
  output logic [LAT_W-1:0] remain,
  output logic [AGE_W-1:0] age
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= 1'b0;
      remain <= '0;
      age    <= '0;
    end else if (rec) begin
      // a new record always wins, even over a same-cycle retire
      valid  <= 1'b1;
      remain <= rec_lat - LAT_W'(1);
      age    <= (rec_lat == LAT_W'(1)) ? AGE_W'(1) : '0;
    end else if (valid) begin
      if (remain != '0) begin
        remain <= remain - LAT_W'(1);
        if (remain == LAT_W'(1)) age <= AGE_W'(1);
      end else if (age < AGE_W'(NUM_FWD)) begin
        age <= age + AGE_W'(1);
      end else begin
        valid <= 1'b0;
        age   <= '0;
      end
    end
  end
endmodule

module fwd_scoreboard #(
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int REG_W   = 5,
  parameter int MAX_LAT = 8,
  parameter int LAT_W   = $clog2(MAX_LAT+1),
  parameter int SEL_W   = $clog2(NUM_FWD+1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            issue_valid,
  input  logic [NUM_SRC-1:0]              src_en,
  input  logic [NUM_SRC-1:0][REG_W-1:0]   src_idx,
  input  logic                            rd_wen,
  input  logic [REG_W-1:0]                rd_idx,
  input  logic [LAT_W-1:0]                rd_lat,
  input  logic                            flush,
  output logic                            issue_stall,
  output logic                            fwd_valid,
  output logic [NUM_SRC-1:0][SEL_W-1:0]   fwd_sel,
  output logic [(1<<REG_W)-1:0]           busy_vec
);
  localparam int NREG  = 1 << REG_W;
  localparam int AGE_W = SEL_W + 1;

  logic [NREG-1:0]            ent_valid;
  logic [NREG-1:0][LAT_W-1:0] ent_remain;
  logic [NREG-1:0][AGE_W-1:0] ent_age;
  logic                       fire, record;
  logic                       raw, waw, wb;
  logic [NUM_SRC-1:0][SEL_W-1:0] sel_nxt;

  assign fire   = issue_valid & ~flush & ~issue_stall;
  assign record = fire & rd_wen & (rd_idx != '0);

  // x0 is hardwired and never tracked
  assign ent_valid[0]  = 1'b0;
  assign ent_remain[0] = '0;
  assign ent_age[0]    = '0;

  genvar r;
  generate
    for (r = 1; r < NREG; r++) begin : g_ent
      fwd_sb_entry #(.LAT_W(LAT_W), .AGE_W(AGE_W), .NUM_FWD(NUM_FWD)) u_ent (
        .clk     (clk),
        .rst     (rst),
        .rec     (record && (rd_idx == REG_W'(r))),
        .rec_lat (rd_lat),
        .valid   (ent_valid[r]),
        .remain  (ent_remain[r]),
        .age     (ent_age[r])
      );
    end
  endgenerate

  always_comb begin
    raw = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      if (src_en[i] && src_idx[i] != '0 && ent_valid[src_idx[i]] &&
          ent_remain[src_idx[i]] != '0)
        raw = 1'b1;
    waw = rd_wen && rd_idx != '0 && ent_valid[rd_idx] && ent_remain[rd_idx] != '0;
    // a producer with remain == rd_lat would hit stage 1 together with the new one
    wb = 1'b0;
    if (rd_wen && rd_idx != '0)
      for (int k = 1; k < NREG; k++)
        if (ent_valid[k] && ent_remain[k] == rd_lat && ent_remain[k] != '0)
          wb = 1'b1;
    issue_stall = issue_valid & ~flush & (raw | waw | wb);
  end

  always_comb begin
    sel_nxt = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (src_en[i] && src_idx[i] != '0 && ent_valid[src_idx[i]] &&
          ent_remain[src_idx[i]] == '0)
        sel_nxt[i] = ent_age[src_idx[i]][SEL_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_valid <= 1'b0;
      fwd_sel   <= '0;
    end else if (fire) begin
      fwd_valid <= 1'b1;
      fwd_sel   <= sel_nxt;
    end else begin
      fwd_valid <= 1'b0;
      fwd_sel   <= '0;
    end
  end

  assign busy_vec = ent_valid;
endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised scoreboard-based forwarding and hazard unit. It is the successor to the fixed two-stage, two-operand forward selector, and sits between ID and EX. It tracks every in-flight register write with its result latency, and stalls issue on RAW-not-ready, WAW, and writeback-port collisions. For every source operand it produces a registered forward-stage select aligned with the consumer's EX cycle. It supports multi-cycle producers (loads, mul/div) and an arbitrary number of forwarding stages and source operands.

## Interface
- NUM_SRC, 2, source operands per instruction
- NUM_FWD, 2, forwarding stages after EX (1 = EX/MEM, 2 = MEM/WB, …); the last stage writes the regfile
- REG_W, 5, register index width; 2^REG_W architectural registers; x0 is never tracked
- MAX_LAT, 8, maximum producer EX latency in cycles (≥1)
- LAT_W, $clog2(MAX_LAT+1), latency field width
- SEL_W, $clog2(NUM_FWD+1), forward select width

- clk  in  1  clock; one clock domain
- rst  in  1  reset, asynchronous, active-high
- issue_valid  in  1  ID holds an instruction requesting issue
- src_en  in  NUM_SRC  per-operand read enable
- src_idx  in  NUM_SRC×REG_W  per-operand register index
- rd_wen  in  1  instruction writes rd
- rd_idx  in  REG_W  destination index
- rd_lat  in  LAT_W  EX latency, 1..MAX_LAT
- flush  in  1  squash the instruction in ID this cycle; it is never recorded
- issue_stall  out  1  combinational; hold ID, inject bubble into EX
- fwd_valid  out  1  registered; EX holds an issued instruction
- fwd_sel  out  NUM_SRC×SEL_W  registered; 0 = regfile, s = forwarding stage s
- busy_vec  out  2^REG_W  registered; entry valid per register (debug)

## Operation
- Each register r has one entry: valid, remain (LAT_W), age (SEL_W+1).
- **Issue fire:**
  - Condition: fire = issue_valid & ~flush & ~issue_stall.
  - Record condition: fire & rd_wen & rd_idx≠0.
  - Recorded entry: valid=1, remain=rd_lat−1, age=1 if rd_lat==1, else age=0.
- **Per-cycle update of valid entries not being written:**
  - If remain>0: remain−1. When remain reaches 0 in this update, age becomes 1.
  - Else, if age<NUM_FWD: age+1.
  - Else: valid=0, retired. The regfile is write-first, so a same-cycle read sees the value.
- **issue_stall** asserts when issue_valid & ~flush and any of the following holds:
  - RAW: some enabled src with nonzero index has a valid entry with remain≠0.
  - WAW: rd_wen and rd_idx≠0 and the rd entry is valid with remain≠0.
  - WB collision: rd_wen and rd_idx≠0 and any valid entry has remain==rd_lat with remain≥1. That producer would reach stage 1 in the same cycle as the new one.
- **fwd_sel[i]**, registered on fire; on no fire: fwd_valid←0, fwd_sel←0.
  - If src_en[i] and src_idx[i]≠0 and the entry is valid with remain==0: the select is age. This is the stage the producer occupies during the consumer's EX.
  - Otherwise the select is 0.
- Youngest wins: a new record overwrites an older entry for the same rd. WAW stall guarantees the older entry's result already exists.
- Simultaneous retire and record of the same rd: the record wins.

## Timing
- Reset, asynchronous: all entries invalid, remain=0, age=0; fwd_valid=0, fwd_sel=0, busy_vec=0.
- issue_stall has zero latency from ID inputs and current state. fwd_sel and fwd_valid have one cycle latency, valid in the consumer's EX cycle.
- **Producer issued in cycle p with latency L:**
  - Dependents stall through cycle p+L−1.
  - A dependent issued in cycle p+L+k−1 gets fwd_sel=k, for k=1..NUM_FWD.
  - From cycle p+L+NUM_FWD the dependent gets fwd_sel=0.
- L=1 back-to-back dependent: no stall, sel=1. L=2 (load-use): one stall cycle, then sel=1.
- rst asserted mid-operation clears everything immediately. In-flight producers are forgotten; the pipeline is flushed with it.
- flush in the same cycle as issue_valid: no record, no stall, fwd_valid←0.

## Test plan
- **Reset and ALU back-to-back forwarding:**
  - Stimulus: reset; issue add x5 (L=1) in cycle 0; add x6←x5,x5 in cycle 1; or x7←x5 in cycle 2; then x5 in cycle 3.
  - Required: no stall; fwd_sel={1,1}, then {2,…}, then 0.
- **Load-use:**
  - Stimulus: lw x3 (L=2) in cycle 0; dependent x3 in cycle 1.
  - Required: issue_stall=1 in cycle 1; issues in cycle 2 with sel=1; fwd_valid=0 in cycle 2.
- **Long latency and WAW:**
  - Stimulus: div x8 (L=6); then add x8 (L=1) next cycle.
  - Required: stall for 5 cycles; busy_vec[8]=1 throughout. A later reader of x8 sees only the youngest entry's stage.
- **Writeback collision:**
  - Stimulus: issue L=3 to x4 in cycle 0; issue L=2 to x9 in cycle 1 (remain(x4)=2==L).
  - Required: stall in cycle 1; x9 issues in cycle 2.
- **x0, disabled operands, and flush:**
  - Stimulus: producer writes x0; consumer reads x0; src_en=0 on a busy register; flush with issue_valid.
  - Required: no stall, sel=0, no entry recorded.
- **Async reset mid-flight:**
  - Stimulus: rst pulse between clock edges while L=8 is pending.
  - Required: busy_vec=0 and fwd_sel=0 immediately; next dependent issues with no stall.
